// File: rtl/ysyx_trap_ctrl_if.sv
// Upstream (decode) and downstream (writeback) handshake bundle for ysyx_trap_ctrl.
// master = decode/writeback side, slave = the trap controller.
interface ysyx_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [11:0]     in_csr_addr;
  logic [XLEN-1:0] in_src;
  logic            in_src_zero;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd_data;
  logic            out_redirect;
  logic [XLEN-1:0] out_redirect_pc;

  modport master (
    output in_valid, in_op, in_csr_addr, in_src, in_src_zero, in_pc, out_ready,
    input  in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc
  );

  modport slave (
    input  in_valid, in_op, in_csr_addr, in_src, in_src_zero, in_pc, out_ready,
    output in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc
  );
endinterface

// File: rtl/ysyx_trap_ctrl.sv
// CSR / trap execution unit: IDLE -> EXEC (one-cycle CSR write pulse) -> RESP.
// Define YSYX_TRAP_EBREAK_EN to make EBREAK trap to mtvec with mcause 3.
module ysyx_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ysyx_trap_ctrl_if.slave bus,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            csr_exu_valid,
  output logic            csr_wen,
  output logic            csr_ecallen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_waddr_add1,
  output logic [XLEN-1:0] csr_wdata_add1
);

  localparam logic [2:0] OP_CSRRW  = 3'd0;
  localparam logic [2:0] OP_CSRRS  = 3'd1;
  localparam logic [2:0] OP_CSRRC  = 3'd2;
  localparam logic [2:0] OP_ECALL  = 3'd3;
  localparam logic [2:0] OP_MRET   = 3'd4;
  localparam logic [2:0] OP_EBREAK = 3'd5;

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;

`ifdef YSYX_TRAP_EBREAK_EN
  localparam bit EBREAK_EN = 1'b1;
`else
  localparam bit EBREAK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_nxt;

  logic [2:0]      op_p0;
  logic [11:0]     addr_p0;
  logic [XLEN-1:0] src_p0;
  logic            src_zero_p0;
  logic [XLEN-1:0] pc_p0;

  logic [XLEN-1:0] rd_data_p1;
  logic            redirect_p1;
  logic [XLEN-1:0] redirect_pc_p1;

  logic            accept;
  logic            is_csr;
  logic            is_trap;
  logic [XLEN-1:0] rd_nxt;
  logic            redirect_nxt;
  logic [XLEN-1:0] redirect_pc_nxt;

  function automatic logic [XLEN-1:0] csr_rmw(input logic [2:0] op,
                                              input logic [XLEN-1:0] rdata,
                                              input logic [XLEN-1:0] src);
    case (op)
      OP_CSRRS: return rdata | src;
      OP_CSRRC: return rdata & ~src;
      default:  return src;
    endcase
  endfunction

  // in_ready is masked while reset is held so every output reads 0 during reset
  assign bus.in_ready        = (state_q == IDLE) && rst_n;
  assign bus.out_valid       = (state_q == RESP);
  assign bus.out_redirect    = (state_q == RESP) && redirect_p1;
  assign bus.out_rd_data     = rd_data_p1;
  assign bus.out_redirect_pc = redirect_pc_p1;

  assign accept  = bus.in_valid && bus.in_ready;
  assign is_csr  = (op_p0 == OP_CSRRW) || (op_p0 == OP_CSRRS) || (op_p0 == OP_CSRRC);
  assign is_trap = (op_p0 == OP_ECALL) || (EBREAK_EN && (op_p0 == OP_EBREAK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt       = state_q;
    csr_exu_valid   = 1'b0;
    csr_wen         = 1'b0;
    csr_ecallen     = 1'b0;
    csr_waddr       = '0;
    csr_wdata       = '0;
    csr_waddr_add1  = '0;
    csr_wdata_add1  = '0;
    rd_nxt          = '0;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = '0;
    case (state_q)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        state_nxt     = RESP;
        csr_exu_valid = 1'b1;
        if (is_csr) begin
          csr_wen   = (op_p0 == OP_CSRRW) || !src_zero_p0;
          csr_waddr = addr_p0;
          csr_wdata = csr_rmw(op_p0, csr_rdata, src_p0);
          rd_nxt    = csr_rdata;
        end else if (is_trap) begin
          csr_wen         = 1'b1;
          csr_ecallen     = 1'b1;
          csr_waddr       = ADDR_MEPC;
          csr_wdata       = pc_p0;
          csr_waddr_add1  = ADDR_MCAUSE;
          csr_wdata_add1  = (op_p0 == OP_ECALL) ? XLEN'(11) : XLEN'(3);
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = csr_mtvec;
        end else if (op_p0 == OP_MRET) begin
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = csr_mepc;
        end
      end
      RESP:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operands captured on the input handshake
  // p1: response fields sampled at the end of EXEC, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0          <= '0;
      addr_p0        <= '0;
      src_p0         <= '0;
      src_zero_p0    <= 1'b0;
      pc_p0          <= '0;
      rd_data_p1     <= '0;
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
    end else begin
      if (accept) begin
        op_p0       <= bus.in_op;
        addr_p0     <= bus.in_csr_addr;
        src_p0      <= bus.in_src;
        src_zero_p0 <= bus.in_src_zero;
        pc_p0       <= bus.in_pc;
      end
      if (state_q == EXEC) begin
        rd_data_p1     <= rd_nxt;
        redirect_p1    <= redirect_nxt;
        redirect_pc_p1 <= redirect_pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_trap_ctrl.sv
// Self-checking bench for ysyx_trap_ctrl: directed cases, reset abort, then random ops
// checked against a rule-level reference model.
module tb_ysyx_trap_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] csr_rdata, csr_mtvec, csr_mepc;
  logic            csr_exu_valid, csr_wen, csr_ecallen;
  logic [11:0]     csr_waddr, csr_waddr_add1;
  logic [XLEN-1:0] csr_wdata, csr_wdata_add1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  ysyx_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .csr_rdata      (csr_rdata),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .csr_exu_valid  (csr_exu_valid),
    .csr_wen        (csr_wen),
    .csr_ecallen    (csr_ecallen),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_waddr_add1 (csr_waddr_add1),
    .csr_wdata_add1 (csr_wdata_add1)
  );

  typedef struct packed {
    logic            wen;
    logic            ecall;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic [11:0]     waddr1;
    logic [XLEN-1:0] wdata1;
    logic            redir;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] rd;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [XLEN-1:0] src, input logic sz,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rdata,
                                 input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] mepc);
    exp_t e;
    e = '0;
    case (op)
      3'd0: begin e.wen = 1'b1; e.waddr = addr; e.wdata = src; e.rd = rdata; end
      3'd1: begin e.wen = !sz; e.waddr = addr; e.wdata = rdata | src; e.rd = rdata; end
      3'd2: begin e.wen = !sz; e.waddr = addr; e.wdata = rdata & ~src; e.rd = rdata; end
      3'd3: begin
        e.wen = 1'b1; e.ecall = 1'b1; e.waddr = 12'h341; e.wdata = pc;
        e.waddr1 = 12'h342; e.wdata1 = 11; e.redir = 1'b1; e.rpc = mtvec;
      end
      3'd4: begin e.redir = 1'b1; e.rpc = mepc; end
`ifdef YSYX_TRAP_EBREAK_EN
      3'd5: begin
        e.wen = 1'b1; e.ecall = 1'b1; e.waddr = 12'h341; e.wdata = pc;
        e.waddr1 = 12'h342; e.wdata1 = 3; e.redir = 1'b1; e.rpc = mtvec;
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Called one step after a rising edge with the DUT idle; returns likewise.
  task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [XLEN-1:0] src,
                       input logic sz, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rdata,
                       input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] mepc, input int stall);
    exp_t e;
    e = model(op, addr, src, sz, pc, rdata, mtvec, mepc);
    chk("idle.in_ready", bus.in_ready, 1);
    chk("idle.exu_valid", csr_exu_valid, 0);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_csr_addr = addr;
    bus.in_src = src; bus.in_src_zero = sz; bus.in_pc = pc;
    csr_rdata = rdata; csr_mtvec = mtvec; csr_mepc = mepc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_op = 3'($urandom); bus.in_csr_addr = 12'($urandom);
    bus.in_src = $urandom; bus.in_src_zero = 1'($urandom); bus.in_pc = $urandom;
    chk("exec.exu_valid", csr_exu_valid, 1);
    chk("exec.in_ready", bus.in_ready, 0);
    chk("exec.out_valid", bus.out_valid, 0);
    chk("exec.wen", csr_wen, e.wen);
    chk("exec.ecallen", csr_ecallen, e.ecall);
    if (e.wen) begin
      chk("exec.waddr", csr_waddr, e.waddr);
      chk("exec.wdata", csr_wdata, e.wdata);
    end
    chk("exec.waddr_add1", csr_waddr_add1, e.waddr1);
    chk("exec.wdata_add1", csr_wdata_add1, e.wdata1);
    @(posedge clk); #1;
    csr_rdata = $urandom; csr_mtvec = $urandom; csr_mepc = $urandom;
    for (int i = 0; i <= stall; i++) begin
      chk("resp.out_valid", bus.out_valid, 1);
      chk("resp.redirect", bus.out_redirect, e.redir);
      chk("resp.rd_data", bus.out_rd_data, e.rd);
      if (e.redir) chk("resp.redirect_pc", bus.out_redirect_pc, e.rpc);
      chk("resp.in_ready", bus.in_ready, 0);
      chk("resp.exu_valid", csr_exu_valid, 0);
      chk("resp.wen", csr_wen, 0);
      chk("resp.ecallen", csr_ecallen, 0);
      if (i < stall) begin
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
      end else begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
      end
    end
    chk("done.out_valid", bus.out_valid, 0);
    chk("done.in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_csr_addr = '0;
    bus.in_src = '0; bus.in_src_zero = 1'b0; bus.in_pc = '0; bus.out_ready = 1'b0;
    csr_rdata = '0; csr_mtvec = '0; csr_mepc = '0;
    #12;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_redirect", bus.out_redirect, 0);
    chk("rst.exu_valid", csr_exu_valid, 0);
    chk("rst.wen", csr_wen, 0);
    chk("rst.rd_data", bus.out_rd_data, 0);
    chk("rst.redirect_pc", bus.out_redirect_pc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", bus.in_ready, 1);

    do_op(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 0);
    do_op(3'd1, 12'h300, 32'h8, 1'b0, 32'h8000_0004, 32'h1800, 32'h0, 32'h0, 1);
    do_op(3'd1, 12'h300, 32'h8, 1'b1, 32'h8000_0008, 32'h1800, 32'h0, 32'h0, 0);
    do_op(3'd2, 12'h300, 32'h8, 1'b0, 32'h8000_000c, 32'h1808, 32'h0, 32'h0, 0);
    do_op(3'd3, 12'h000, 32'h0, 1'b1, 32'h8000_0044, 32'h0, 32'h8000_0200, 32'h0, 0);
    do_op(3'd4, 12'h000, 32'h0, 1'b1, 32'h8000_0050, 32'h0, 32'h8000_0200, 32'h8000_0048, 5);
    do_op(3'd5, 12'h000, 32'h0, 1'b1, 32'h8000_0060, 32'h0, 32'h8000_0300, 32'h0, 0);
    do_op(3'd6, 12'h123, 32'hdead_beef, 1'b0, 32'h8000_0064, 32'h5555, 32'h8000_0300, 32'h1, 0);

    // reset asserted mid-EXEC must clear outputs without a clock edge
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_csr_addr = 12'h305;
    bus.in_src = 32'h1234; bus.in_src_zero = 1'b0; csr_rdata = 32'hffff;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("abort.pre_wen", csr_wen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.exu_valid", csr_exu_valid, 0);
    chk("abort.wen", csr_wen, 0);
    chk("abort.ecallen", csr_ecallen, 0);
    chk("abort.waddr", csr_waddr, 0);
    chk("abort.wdata", csr_wdata, 0);
    chk("abort.out_valid", bus.out_valid, 0);
    chk("abort.out_redirect", bus.out_redirect, 0);
    chk("abort.rd_data", bus.out_rd_data, 0);
    chk("abort.redirect_pc", bus.out_redirect_pc, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort.post_in_ready", bus.in_ready, 1);
      chk("abort.post_out_valid", bus.out_valid, 0);
      chk("abort.post_exu_valid", csr_exu_valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      do_op(3'($urandom_range(0, 7)), 12'($urandom), $urandom, 1'($urandom),
            $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_trap_ctrl.md
YSYX_TRAP_CTRL -- requirements
Module: ysyx_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data and PC width.
REQ-002 SHALL have port clk  in  1  system clock; one clock only.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid in 1 and in_ready out 1: the upstream (decode) handshake.
REQ-005 SHALL have port in_op  in  3  operation: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5 EBREAK; 6-7 are reserved.
REQ-006 SHALL have ports in_csr_addr in 12, in_src in XLEN, in_src_zero in 1 (rs1==x0 or uimm==0), and in_pc in XLEN.
REQ-007 SHALL have ports csr_rdata in XLEN, csr_mtvec in XLEN and csr_mepc in XLEN, all driven by the CSR register file.
REQ-008 SHALL have CSR-file write ports: csr_exu_valid out 1, csr_wen out 1, csr_ecallen out 1, csr_waddr out 12, csr_wdata out XLEN, csr_waddr_add1 out 12, csr_wdata_add1 out XLEN.
REQ-009 SHALL have ports out_valid out 1 and out_ready in 1: the downstream (writeback) handshake.
REQ-010 SHALL have ports out_rd_data out XLEN, out_redirect out 1 and out_redirect_pc out XLEN.

Function
REQ-011 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-012 SHALL assert in_ready only in IDLE.
- in_valid&in_ready captures op, addr, src, src_zero and pc.
- The same handshake moves the FSM IDLE->EXEC.
REQ-013 SHALL spend exactly one cycle in EXEC.
- csr_exu_valid=1 only in EXEC.
- Captures out_rd_data<=csr_rdata.
- EXEC->RESP unconditionally.
REQ-014 CSRRW: csr_wen=1, csr_waddr=addr, csr_wdata=src.
REQ-015 CSRRS: csr_wdata=csr_rdata|src; CSRRC: csr_wdata=csr_rdata&~src; for both, csr_wen=!src_zero.
REQ-016 ECALL: csr_wen=1 and csr_ecallen=1.
- csr_waddr=0x341 (mepc), csr_wdata=pc.
- csr_waddr_add1=0x342 (mcause), csr_wdata_add1=11.
- Redirect target = csr_mtvec sampled in EXEC.
REQ-017 MRET: csr_wen=0; redirect target = csr_mepc sampled in EXEC.
REQ-018 When a port is unused, csr_waddr_add1 SHALL be 0x000 and csr_wdata_add1 SHALL be 0.
- Port 1 always wins a same-address conflict.
REQ-019 Outside EXEC, all csr_* outputs SHALL be 0.
REQ-020 Redirect and data outputs in RESP:
- out_valid=1.
- out_redirect=1 for ECALL/MRET and for EBREAK when trapping.
- out_redirect_pc and out_rd_data are held stable until out_valid&out_ready.
- That handshake moves RESP->IDLE.
REQ-021 out_rd_data SHALL be 0 for ECALL, MRET and EBREAK.
REQ-022 Reserved ops SHALL complete with no CSR write, no redirect and out_rd_data=0.
REQ-023 Total latency SHALL be 2 cycles from the input handshake to out_valid, with a minimum of 3 cycles between accepts.
REQ-024 out_ready stalls of any length SHALL hold RESP; inputs presented during RESP SHALL NOT be accepted.

Reset
REQ-025 rst_n low SHALL asynchronously force:
- state=IDLE;
- in_ready=1 after release; out_valid, out_redirect, csr_exu_valid, csr_wen and csr_ecallen=0;
- out_rd_data, out_redirect_pc and all captured registers=0.
REQ-026 Reset asserted mid-operation (EXEC or RESP) SHALL abort the operation.
- The CSR write pulse is dropped when reset arrives before the EXEC edge.
- No out_valid is issued for the aborted operation.

Configuration
REQ-027 SHALL use macro YSYX_TRAP_EBREAK_EN.
- Defined: EBREAK acts as ECALL, but with csr_wdata_add1=3 (breakpoint), and redirects to mtvec.
- Undefined: EBREAK performs no CSR write and no redirect, and completes like a reserved op.

Verification
REQ-028 CSRRW: addr=0x305, src=0x80000100, csr_rdata=0x0.
- EXEC: csr_wen=1, csr_waddr=0x305, csr_wdata=0x80000100.
- RESP: out_rd_data=0.
REQ-029 CSRRS: src=0x8, csr_rdata=0x1800 -> csr_wdata=0x1808.
- Same op with src_zero=1 -> csr_wen=0, out_rd_data=0x1800.
REQ-030 ECALL: pc=0x80000044, mtvec=0x80000200.
- EXEC: mepc write 0x80000044, mcause write 11, csr_ecallen=1.
- RESP: out_redirect=1, out_redirect_pc=0x80000200.
REQ-031 MRET with mepc=0x80000048 -> no CSR write; out_redirect_pc=0x80000048.
- out_ready held low 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-032 EBREAK with macro defined -> mcause write 3 and redirect to mtvec.
- Without the macro -> no write, out_redirect=0.
REQ-033 rst_n low during EXEC -> all outputs 0 immediately, without waiting for a clock edge.
- After release: IDLE, in_ready=1, no out_valid.
